// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-bit bitwise logic unit.
// Grant is combinational; operands are latched, then the result is registered (two-cycle latency).
module logic_unit_arbiter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req0_i,
  input  logic [1:0]       op0_i,
  input  logic [Width-1:0] a0_i,
  input  logic [Width-1:0] b0_i,
  input  logic             req1_i,
  input  logic [1:0]       op1_i,
  input  logic [Width-1:0] a1_i,
  input  logic [Width-1:0] b1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic [Width-1:0] data_result_o,
  output logic             busy_o
);

  logic             last_q, last_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_id_q, s1_id_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [Width-1:0] s1_a_q, s1_a_d;
  logic [Width-1:0] s1_b_q, s1_b_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [Width-1:0] result_q, result_d;
  logic [Width-1:0] alu_res;
  logic             gnt0, gnt1;

  // last_q names the most recently granted port; a contested cycle goes to the other one.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i && !flush_i) begin
      if (req0_i && req1_i) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (req0_i) begin
        gnt0 = 1'b1;
      end else if (req1_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    last_d     = last_q;
    s1_valid_d = gnt0 | gnt1;
    s1_id_d    = gnt1;
    s1_op_d    = gnt1 ? op1_i : op0_i;
    s1_a_d     = gnt1 ? a1_i  : a0_i;
    s1_b_d     = gnt1 ? b1_i  : b0_i;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  always_comb begin
    alu_res = '0;
    unique case (s1_op_q)
      2'b00:   alu_res = s1_a_q & s1_b_q;
      2'b01:   alu_res = s1_a_q | s1_b_q;
      2'b10:   alu_res = s1_a_q ^ s1_b_q;
      2'b11:   alu_res = ~s1_a_q;
      default: alu_res = '0;
    endcase
  end

  // Flush kills the stage-1 op; a done already registered this cycle is left visible.
  always_comb begin
    done0_d  = s1_valid_q && !s1_id_q && !flush_i;
    done1_d  = s1_valid_q &&  s1_id_q && !flush_i;
    result_d = (s1_valid_q && !flush_i) ? alu_res : result_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      result_q   <= result_d;
    end
  end

  // Operand fields are only meaningful alongside s1_valid_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    s1_id_q <= s1_id_d;
    s1_op_q <= s1_op_d;
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
  end

  assign gnt0_o        = gnt0;
  assign gnt1_o        = gnt1;
  assign done0_o       = done0_q;
  assign done1_o       = done1_q;
  assign data_result_o = result_q;
  assign busy_o        = s1_valid_q | done0_q | done1_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios then constrained-random traffic,
// all checked against a queue-based reference model of grants and completions.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush, req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] data_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          port;
    logic [31:0] res;
    int          due;
  } op_t;

  op_t         q[$];
  logic [31:0] m_result = '0;
  bit          m_last   = 1'b1;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.Width(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req0_i        (req0),
    .op0_i         (op0),
    .a0_i          (a0),
    .b0_i          (b0),
    .req1_i        (req1),
    .op1_i         (op1),
    .a1_i          (a1),
    .b1_i          (b1),
    .gnt0_o        (gnt0),
    .gnt1_o        (gnt1),
    .done0_o       (done0),
    .done1_o       (done1),
    .data_result_o (data_result),
    .busy_o        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict and compare outputs, then advance the model.
  task automatic run_cycle(input logic rst_v, input logic fl_v,
                           input logic r0, input logic [1:0] o0,
                           input logic [31:0] x0, input logic [31:0] y0,
                           input logic r1, input logic [1:0] o1,
                           input logic [31:0] x1, input logic [31:0] y1,
                           output logic eg0, output logic eg1);
    logic ed0, ed1, ebusy;
    op_t  e;
    @(posedge clk);
    cyc++;
    #1;
    rst = rst_v; flush = fl_v;
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    ed0 = 1'b0;
    ed1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      m_result = e.res;
      if (e.port) ed1 = 1'b1;
      else        ed0 = 1'b1;
    end
    ebusy = ed0 | ed1 | (q.size() > 0 && q[0].due == cyc + 1);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst_v && !fl_v) begin
      if (r0 && r1) begin
        eg0 = (m_last == 1'b1);
        eg1 = (m_last == 1'b0);
      end else begin
        eg0 = r0;
        eg1 = r1;
      end
    end
    #3;
    check_eq("gnt0", {31'b0, gnt0}, {31'b0, eg0});
    check_eq("gnt1", {31'b0, gnt1}, {31'b0, eg1});
    check_eq("done0", {31'b0, done0}, {31'b0, ed0});
    check_eq("done1", {31'b0, done1}, {31'b0, ed1});
    check_eq("busy", {31'b0, busy}, {31'b0, ebusy});
    check_eq("data_result", data_result, m_result);
    if (rst_v) begin
      q.delete();
      m_result = '0;
      m_last   = 1'b1;
    end else if (fl_v) begin
      q.delete();
    end else if (eg0 || eg1) begin
      e.port = eg1;
      e.res  = eg1 ? ref_fn(o1, x1, y1) : ref_fn(o0, x0, y0);
      e.due  = cyc + 2;
      q.push_back(e);
      m_last = eg1;
    end
  endtask

  initial begin
    logic        g0, g1;
    bit          pend0, pend1;
    logic [1:0]  ro0, ro1;
    logic [31:0] ra0, rb0, ra1, rb1;
    logic        rrst, rfl;

    rst = 1'b1; flush = 1'b0;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;

    // Reset held three cycles.
    repeat (3) run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Single AND on port 0.
    run_cycle(0, 0, 1, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 0, 0, g0, g1);
    check_eq("and_gnt", {31'b0, gnt0}, 32'd1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    check_eq("and_res", data_result, 32'h0F0F0000);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Round-robin with both ports held after a reset.
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    repeat (6) run_cycle(0, 0, 1, 2'b01, 32'h0000FF00, 32'h000000FF,
                         1, 2'b10, 32'hAAAAAAAA, 32'h55555555, g0, g1);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // NOT then OR back-to-back on port 1.
    run_cycle(0, 0, 0, 0, 0, 0, 1, 2'b11, 32'h12345678, 32'hDEADBEEF, g0, g1);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 2'b01, 32'h000000F0, 32'h00000F00, g0, g1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    check_eq("not_res", data_result, 32'hEDCBA987);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    check_eq("or_res", data_result, 32'h00000FF0);
    check_eq("or_done1", {31'b0, done1}, 32'd1);

    // Flush kills the op granted the cycle before; port 1 still favoured afterwards.
    run_cycle(0, 0, 1, 2'b10, 32'h0000FFFF, 32'h00FF00FF, 0, 0, 0, 0, g0, g1);
    run_cycle(0, 1, 0, 0, 0, 0, 1, 2'b00, 32'hFFFFFFFF, 32'h1234ABCD, g0, g1);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    check_eq("flush_hold", data_result, 32'h00000FF0);
    run_cycle(0, 0, 1, 2'b00, 32'h1, 32'h1, 1, 2'b00, 32'hFFFFFFFF, 32'h1234ABCD, g0, g1);
    check_eq("flush_rr", {30'b0, gnt1, gnt0}, 32'd2);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Reset the cycle after a grant; port 0 wins the next contest.
    run_cycle(0, 0, 0, 0, 0, 0, 1, 2'b01, 32'hF0F0F0F0, 32'h0000000F, g0, g1);
    run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    run_cycle(0, 0, 1, 2'b10, 32'h3, 32'h5, 1, 2'b10, 32'h7, 32'h9, g0, g1);
    check_eq("rst_result", data_result, 32'h0);
    check_eq("rst_rr", {30'b0, gnt1, gnt0}, 32'd1);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // Random traffic: ungranted requests hold their operands until granted.
    pend0 = 0; pend1 = 0;
    ro0 = '0; ra0 = '0; rb0 = '0; ro1 = '0; ra1 = '0; rb1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend0 && ($urandom % 4 != 0)) begin
        pend0 = 1; ro0 = 2'($urandom); ra0 = $urandom; rb0 = $urandom;
      end
      if (!pend1 && ($urandom % 3 != 0)) begin
        pend1 = 1; ro1 = 2'($urandom); ra1 = $urandom; rb1 = $urandom;
      end
      rrst = ($urandom % 50 == 0);
      rfl  = ($urandom % 12 == 0);
      run_cycle(rrst, rfl, pend0, ro0, ra0, rb0, pend1, ro1, ra1, rb1, g0, g1);
      if (g0) pend0 = 0;
      if (g1) pend1 = 0;
    end
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters, typically the execute stage (port 0) and the multdiv/branch helper (port 1). It grants at most one request per cycle with round-robin fairness. It latches the granted operands, computes the result in a registered two-stage pipeline, and returns the result with a one-cycle done pulse tagged to the winning requester. Throughput is one operation per cycle; latency is two cycles.

## Interface
- WIDTH, 32, operand/result width in bits.
- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- req0 / req1  in  1  request from requester 0 / 1; held high with operands stable until granted.
- op0 / op1  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT A (B ignored).
- a0, b0 / a1, b1  in  WIDTH  operands for requester 0 / 1.
- gnt0 / gnt1  out  1  combinational grant; operands are sampled at the edge ending a cycle with gnt high.
- done0 / done1  out  1  registered one-cycle pulse; data_result is valid for that requester.
- data_result  out  WIDTH  registered result.
- busy  out  1  high while any operation is in stage 1 or stage 2.

## Operation
- Arbitration pointer `last` (1 bit) records the last granted port. Reset sets last=1, so port 0 wins the first contest.
- Grant logic, with reset=0 and flush=0:
  - Only req0 → gnt0.
  - Only req1 → gnt1.
  - Both → grant the port ≠ last.
  - Neither → no grant.
- gnt0 and gnt1 are never high together.
- Both grants are forced low while reset or flush is high.
- last updates only on an edge where a grant occurred.
- Stage 1 register (s1_valid, s1_id, s1_op, s1_a, s1_b) loads on every edge:
  - s1_valid = granted this cycle.
  - s1_id = winning port.
  - Operand fields are don't-care when s1_valid=0.
- Stage 2 computes f(s1_op, s1_a, s1_b) bitwise over all WIDTH bits, with no carries or width growth.
  - Registers into data_result only when s1_valid=1; otherwise data_result holds its value.
  - done[s1_id] is registered from s1_valid; the other done is 0.
- busy = s1_valid | (done0 | done1).
- flush clears s1_valid and both done outputs at the edge.
  - data_result holds.
  - last is unchanged.
  - The killed operations never produce done, and requesters must re-request.
- reset clears last→1, s1_valid→0, done0/done1→0, data_result→0.
  - Any operation in flight when reset asserts is dropped.
- Reset values of all outputs: gnt0=gnt1=0, done0=done1=0, data_result=0, busy=0.

## Timing
- Cycle N: req and gnt high.
- Edge N/N+1: operands captured.
- Cycle N+1: computation.
- Edge N+1/N+2: result registered.
- Cycle N+2: doneX=1 and data_result valid. Latency is 2 cycles from the grant cycle.
- Back-to-back: a new grant is allowed every cycle, with no bubble. Results appear in grant order, one per cycle.
- A requester may drop req the cycle after its grant, or keep it high to issue another operation.
  - With both ports requesting continuously, grants strictly alternate.
- A request that is not granted must stay asserted, with stable operands, until it is granted.
- Flush or reset asserted in cycle N:
  - No grant in cycle N.
  - No done in cycle N+1.
  - An op granted in N-1 produces no done.
- An op granted in N-2 whose done is in cycle N is not cancelled: done is already registered and is visible.

## Test plan
- Reset values: hold reset 3 cycles → gnt0=gnt1=done0=done1=busy=0 and data_result=0x00000000.
- Single AND: req0, op0=00, a0=0xFFFF0000, b0=0x0F0F0F0F in cycle 5 → gnt0=1 in cycle 5; done0=1 and data_result=0x0F0F0000 in cycle 7 only.
- Round-robin: req0 and req1 held high for 6 cycles after reset → grants in order 0,1,0,1,0,1. Done pulses follow two cycles later in the same order, with correct per-port results (e.g. port 1 XOR 0xAAAAAAAA^0x55555555 = 0xFFFFFFFF).
- NOT and pipelining: port 1 issues NOT 0x12345678 and then OR 0x00F0, 0x0F00 on consecutive cycles → data_result=0xEDCBA987, then 0x00000FF0, on consecutive cycles with done1 high for both.
- Flush: grant port 0 in cycle 10, flush=1 in cycle 11 with req1 high → gnt1=0 in cycle 11; no done in cycles 12–13; data_result unchanged; the next contest still favours port 1.
- Reset mid-operation: grant in cycle 20, reset in cycle 21 → done never asserts; outputs return to their reset values; port 0 wins the first post-reset contest.
